control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired fetch/execute control sequencer for the phase-2 datapath. It replaces the hand-driven T0–T5 stimulus with a synthesizable FSM that fetches an instruction, decodes its register fields, and drives the bus-encoder, register-enable and ALU-opcode lines of `DataPath`. It is parametrised in register count and opcode width, adds memory wait states, and adds two-cycle HI/LO writeback for MUL/DIV.

## Interface
- `NUM_REGS`, 16: general-purpose registers; register field width `RF_W = $clog2(NUM_REGS)`.
- `DATA_W`, 32: instruction/IR width.
- `OPCODE_W`, 5: opcode field width, IR[DATA_W-1 -: OPCODE_W].

- `clock` in 1: single clock, rising edge.
- `clear` in 1: reset, asynchronous, active-low.
- `run` in 1: start/continue execution; sampled in IDLE and at each instruction end.
- `ir` in DATA_W: IR register contents from the datapath.
- `mem_ready` in 1: memory read data valid this cycle.
- `PCout, Zlowout, Zhighout, MDRout` out 1 each: bus-encoder source selects.
- `MARin, PCin, MDRin, IRin, RYin, RZin, HIin, LOin` out 1 each: register load enables.
- `IncPC, Mem_read` out 1 each: ALU PC-increment, memory read strobe.
- `reg_out` out NUM_REGS: one-hot GPR bus-source select.
- `reg_in` out NUM_REGS: one-hot GPR load enable.
- `alu_op` out OPCODE_W: ALU operation; 0 outside T4.
- `done` out 1: one-cycle pulse in the final state of each completed instruction.
- `illegal` out 1: one-cycle pulse on an undefined opcode.

## Operation
- IR fields: opcode = top OPCODE_W bits; ra, rb, rc = next three RF_W-bit fields, MSB-first. Example: 0x28918000 decodes to opcode 00101 (AND), ra=1, rb=2, rc=3.
- Opcode classes:
  - ALU3: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011.
  - MULDIV: MUL 01111, DIV 10000.
  - UNARY: NEG 10001, NOT 10010.
  - Every other opcode is illegal.
- States and their asserted outputs (each listed signal is high for the whole state; all others 0):
  - IDLE: none. Go to T0 when run=1.
  - T0: PCout, MARin, IncPC, RZin.
  - T1: Zlowout, PCin, Mem_read, MDRin. Stay in T1 while mem_ready=0; go to T2 on mem_ready=1. Repeating PCin is idempotent because Z is unchanged.
  - T2: MDRout, IRin.
  - T3: reg_out[rb], RYin. If the opcode is illegal, assert only `illegal` and exit instead.
  - T4: reg_out[rc] (ALU3, MULDIV) or reg_out[rb] (UNARY); alu_op = opcode; RZin.
  - T5: ALU3/UNARY: Zlowout, reg_in[ra], done. MULDIV: Zlowout, LOin.
  - T6 (MULDIV only): Zhighout, HIin, done.
- Instruction exit (last state, or illegal in T3): go to T0 if run=1, else IDLE.
- No special treatment of R0; `reg_in`/`reg_out` are strictly one-hot or zero.

## Timing
- Outputs are Moore: decoded from the state register, plus `ir` fields in T3–T6. `ir` must be stable from the cycle after T2.
- Reset value: state IDLE; every output 0, including alu_op, reg_in and reg_out.
- `clear` asserted mid-instruction aborts immediately (async); no partial writeback completes after reset.
- Latency with zero wait states: ALU3/UNARY 6 cycles, MULDIV 7 cycles, illegal 4 cycles. Each mem_ready=0 cycle in T1 adds one cycle.
- mem_ready high in T0 is ignored; it is only sampled in T1.
- Back-to-back: with run held high, T0 of the next instruction follows the done cycle directly.
- Dropping run mid-instruction does not abort; the instruction completes, then the FSM goes to IDLE.

## Structure
- `cpu_ctrl_pkg`: opcode localparams, class enum {ALU3, MULDIV, UNARY, ILLEGAL}, state enum (IDLE, T0–T6; 3-bit encoding).
- Sub-module `instr_decoder`, purely combinational and parametrised like the parent: ir → opcode, ra, rb, rc, class.
- `control_sequencer` holds the state register, next-state logic and output decode.

## Test plan
- Reset with run=1, ir=0x28918000, mem_ready=1: sequence T0..T5; T3 reg_out=0x0004; T4 reg_out=0x0008, alu_op=00101; T5 reg_in=0x0002 and done=1; 6 cycles total.
- Same instruction, mem_ready low for 3 cycles in T1: Mem_read/MDRin high for 4 cycles, done on cycle 9.
- MUL (ir=0x7891_8000, rb=2, rc=3): T5 asserts LOin+Zlowout, T6 asserts HIin+Zhighout+done; reg_in stays 0 throughout.
- Opcode 11111: illegal pulses in T3, no RYin and no reg_in; next state T0 if run=1.
- Assert clear in T4: all outputs 0 asynchronously; after release with run=0 the FSM stays in IDLE.
- NUM_REGS=32 build: ra field is IR[26:22]; writing R31 sets reg_in bit 31.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode, class and state definitions for the
// fetch/execute control sequencer.
package cpu_ctrl_pkg;

  localparam int OP_ADD  = 3;
  localparam int OP_SUB  = 4;
  localparam int OP_AND  = 5;
  localparam int OP_OR   = 6;
  localparam int OP_SHR  = 7;
  localparam int OP_SHRA = 8;
  localparam int OP_SHL  = 9;
  localparam int OP_ROR  = 10;
  localparam int OP_ROL  = 11;
  localparam int OP_MUL  = 15;
  localparam int OP_DIV  = 16;
  localparam int OP_NEG  = 17;
  localparam int OP_NOT  = 18;

  typedef enum logic [1:0] {
    CLS_ALU3,
    CLS_MULDIV,
    CLS_UNARY,
    CLS_ILLEGAL
  } instr_class_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6
  } state_e;

endpackage

// File: rtl/instr_decoder.sv
// Splits the instruction register into opcode and register
// fields and classifies the opcode.
module instr_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32,
  parameter int OPCODE_W = 5,
  localparam int RF_W    = $clog2(NUM_REGS)
) (
  input  logic [DATA_W-1:0]   ir,
  output logic [OPCODE_W-1:0] opcode,
  output logic [RF_W-1:0]     ra,
  output logic [RF_W-1:0]     rb,
  output logic [RF_W-1:0]     rc,
  output instr_class_e        cls
);

  localparam int LOW_W = DATA_W - OPCODE_W - 3 * RF_W;

  logic is_alu;
  logic is_md;
  logic is_un;
  logic unused_low;

  assign opcode = ir[DATA_W-1 -: OPCODE_W];
  assign ra     = ir[DATA_W-OPCODE_W-1 -: RF_W];
  assign rb     = ir[DATA_W-OPCODE_W-RF_W-1 -: RF_W];
  assign rc     = ir[DATA_W-OPCODE_W-2*RF_W-1 -: RF_W];

  assign unused_low = ^ir[LOW_W-1:0];

  always_comb begin
    is_alu = opcode inside {
      OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB),
      OPCODE_W'(OP_AND), OPCODE_W'(OP_OR),
      OPCODE_W'(OP_SHR), OPCODE_W'(OP_SHRA),
      OPCODE_W'(OP_SHL), OPCODE_W'(OP_ROR),
      OPCODE_W'(OP_ROL)
    };
    is_md = opcode inside {
      OPCODE_W'(OP_MUL), OPCODE_W'(OP_DIV)
    };
    is_un = opcode inside {
      OPCODE_W'(OP_NEG), OPCODE_W'(OP_NOT)
    };
  end

  always_comb begin
    cls = CLS_ILLEGAL;
    unique case (1'b1)
      is_alu:  cls = CLS_ALU3;
      is_md:   cls = CLS_MULDIV;
      is_un:   cls = CLS_UNARY;
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute FSM driving bus selects, register
// enables and ALU opcode for the phase-2 datapath.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32,
  parameter int OPCODE_W = 5
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic [DATA_W-1:0]   ir,
  input  logic                mem_ready,
  output logic                PCout,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                MDRout,
  output logic                MARin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                RYin,
  output logic                RZin,
  output logic                HIin,
  output logic                LOin,
  output logic                IncPC,
  output logic                Mem_read,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [OPCODE_W-1:0] alu_op,
  output logic                done,
  output logic                illegal
);

  localparam int RF_W = $clog2(NUM_REGS);
  localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);

  state_e              state_q;
  state_e              state_d;
  state_e              exit_st;
  logic [OPCODE_W-1:0] opcode;
  logic [RF_W-1:0]     ra;
  logic [RF_W-1:0]     rb;
  logic [RF_W-1:0]     rc;
  instr_class_e        cls;

  instr_decoder #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .OPCODE_W (OPCODE_W)
  ) u_dec (
    .ir     (ir),
    .opcode (opcode),
    .ra     (ra),
    .rb     (rb),
    .rc     (rc),
    .cls    (cls)
  );

  assign exit_st = run ? S_T0 : S_IDLE;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: state_d = run ? S_T0 : S_IDLE;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = mem_ready ? S_T2 : S_T1;
      S_T2:   state_d = S_T3;
      S_T3:   state_d = (cls == CLS_ILLEGAL) ? exit_st : S_T4;
      S_T4:   state_d = S_T5;
      S_T5:   state_d = (cls == CLS_MULDIV) ? S_T6 : exit_st;
      S_T6:   state_d = exit_st;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Moore decode; T3..T6 also use the IR fields, stable after T2
  always_comb begin
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    RYin     = 1'b0;
    RZin     = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IncPC    = 1'b0;
    Mem_read = 1'b0;
    reg_out  = '0;
    reg_in   = '0;
    alu_op   = '0;
    done     = 1'b0;
    illegal  = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        RZin  = 1'b1;
      end
      S_T1: begin
        Zlowout  = 1'b1;
        PCin     = 1'b1;
        Mem_read = 1'b1;
        MDRin    = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (cls == CLS_ILLEGAL) begin
          illegal = 1'b1;
        end else begin
          reg_out = ONE << rb;
          RYin    = 1'b1;
        end
      end
      S_T4: begin
        reg_out = (cls == CLS_UNARY) ? (ONE << rb)
                                     : (ONE << rc);
        alu_op  = opcode;
        RZin    = 1'b1;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (cls == CLS_MULDIV) begin
          LOin = 1'b1;
        end else begin
          reg_in = ONE << ra;
          done   = 1'b1;
        end
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: a cycle-trace model
// built from the state table checks 16- and 32-register builds.
module tb_control_sequencer;

  typedef struct packed {
    logic [13:0] ctl;
    logic [31:0] ro;
    logic [31:0] ri;
    logic [4:0]  op;
    logic        done;
    logic        ill;
  } obs_t;

  localparam int PCOUT  = 13;
  localparam int ZLO    = 12;
  localparam int ZHI    = 11;
  localparam int MDROUT = 10;
  localparam int MARIN  = 9;
  localparam int PCIN   = 8;
  localparam int MDRIN  = 7;
  localparam int IRIN   = 6;
  localparam int RYIN   = 5;
  localparam int RZIN   = 4;
  localparam int HIIN   = 3;
  localparam int LOIN   = 2;
  localparam int INCPC  = 1;
  localparam int MEMRD  = 0;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        run = 1'b0;
  logic [31:0] ir = '0;
  logic        mem_ready = 1'b0;

  logic [13:0] c16;
  logic [15:0] ro16;
  logic [15:0] ri16;
  logic [4:0]  op16;
  logic        d16;
  logic        il16;

  logic [13:0] c32;
  logic [31:0] ro32;
  logic [31:0] ri32;
  logic [4:0]  op32;
  logic        d32;
  logic        il32;

  obs_t a16;
  obs_t a32;
  obs_t exp16[$];
  obs_t exp32[$];

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  control_sequencer dut (
    .clock(clock), .clear(clear), .run(run),
    .ir(ir), .mem_ready(mem_ready),
    .PCout(c16[13]), .Zlowout(c16[12]),
    .Zhighout(c16[11]), .MDRout(c16[10]),
    .MARin(c16[9]), .PCin(c16[8]),
    .MDRin(c16[7]), .IRin(c16[6]),
    .RYin(c16[5]), .RZin(c16[4]),
    .HIin(c16[3]), .LOin(c16[2]),
    .IncPC(c16[1]), .Mem_read(c16[0]),
    .reg_out(ro16), .reg_in(ri16),
    .alu_op(op16), .done(d16), .illegal(il16)
  );

  control_sequencer #(.NUM_REGS(32)) dut32 (
    .clock(clock), .clear(clear), .run(run),
    .ir(ir), .mem_ready(mem_ready),
    .PCout(c32[13]), .Zlowout(c32[12]),
    .Zhighout(c32[11]), .MDRout(c32[10]),
    .MARin(c32[9]), .PCin(c32[8]),
    .MDRin(c32[7]), .IRin(c32[6]),
    .RYin(c32[5]), .RZin(c32[4]),
    .HIin(c32[3]), .LOin(c32[2]),
    .IncPC(c32[1]), .Mem_read(c32[0]),
    .reg_out(ro32), .reg_in(ri32),
    .alu_op(op32), .done(d32), .illegal(il32)
  );

  assign a16 = {c16, 16'b0, ro16, 16'b0, ri16,
                op16, d16, il16};
  assign a32 = {c32, ro32, ri32, op32, d32, il32};

  task automatic push(input int rfw, input obs_t e);
    if (rfw == 4) exp16.push_back(e);
    else          exp32.push_back(e);
  endtask

  // Expected per-cycle outputs of one instruction
  task automatic build(input logic [31:0] i,
                       input int waits, input int rfw);
    int op, ra, rb, rc, mask;
    bit alu, md, un;
    obs_t e;
    mask = (1 << rfw) - 1;
    op = int'(i[31:27]);
    ra = int'(i >> (27 - rfw)) & mask;
    rb = int'(i >> (27 - 2 * rfw)) & mask;
    rc = int'(i >> (27 - 3 * rfw)) & mask;
    alu = op inside {[3:11]};
    md  = op inside {[15:16]};
    un  = op inside {[17:18]};
    e = '0;
    e.ctl[PCOUT] = 1; e.ctl[MARIN] = 1;
    e.ctl[INCPC] = 1; e.ctl[RZIN] = 1;
    push(rfw, e);
    e = '0;
    e.ctl[ZLO] = 1; e.ctl[PCIN] = 1;
    e.ctl[MEMRD] = 1; e.ctl[MDRIN] = 1;
    for (int w = 0; w <= waits; w++) push(rfw, e);
    e = '0;
    e.ctl[MDROUT] = 1; e.ctl[IRIN] = 1;
    push(rfw, e);
    e = '0;
    if (!(alu || md || un)) begin
      e.ill = 1;
      push(rfw, e);
      return;
    end
    e.ro = 32'(1) << rb; e.ctl[RYIN] = 1;
    push(rfw, e);
    e = '0;
    e.ro = 32'(1) << (un ? rb : rc);
    e.op = 5'(op); e.ctl[RZIN] = 1;
    push(rfw, e);
    e = '0;
    e.ctl[ZLO] = 1;
    if (md) begin
      e.ctl[LOIN] = 1;
      push(rfw, e);
      e = '0;
      e.ctl[ZHI] = 1; e.ctl[HIIN] = 1; e.done = 1;
      push(rfw, e);
    end else begin
      e.ri = 32'(1) << ra; e.done = 1;
      push(rfw, e);
    end
  endtask

  task automatic cmp_zero(input string name);
    checks++;
    if (a16 !== '0 || a32 !== '0) begin
      failures++;
      $display("FAIL %s act16=%h act32=%h exp=0",
               name, a16, a32);
    end
  endtask

  task automatic check_idle(input string name, input int n);
    repeat (n) begin
      @(negedge clock);
      #1 cmp_zero(name);
    end
  endtask

  task automatic go();
    @(negedge clock);
    run = 1'b1;
  endtask

  // Caller leaves run=1 so the next posedge enters T0
  task automatic exec(input string name,
                      input logic [31:0] i,
                      input int waits,
                      input bit run_after,
                      input int drop_at,
                      input int abort_at,
                      input bit t0_ready);
    int n;
    exp16.delete();
    exp32.delete();
    build(i, waits, 4);
    build(i, waits, 5);
    n = exp16.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      if (k == 0) begin
        ir = i;
        mem_ready = t0_ready ? 1'b1 : 1'($urandom_range(0, 1));
      end else if (k <= waits) begin
        mem_ready = 1'b0;
      end else if (k == waits + 1) begin
        mem_ready = 1'b1;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      if (k == n - 1) run = run_after;
      else if (drop_at >= 0 && k >= drop_at) run = 1'b0;
      else run = 1'b1;
      #1;
      checks++;
      if (a16 !== exp16[k]) begin
        failures++;
        $display("FAIL %s cyc%0d r16 act=%h exp=%h",
                 name, k, a16, exp16[k]);
      end
      checks++;
      if (a32 !== exp32[k]) begin
        failures++;
        $display("FAIL %s cyc%0d r32 act=%h exp=%h",
                 name, k, a32, exp32[k]);
      end
      if (k == abort_at) break;
    end
  endtask

  function automatic logic [31:0] rand_ir(input int cls);
    int op;
    unique case (cls)
      0: op = $urandom_range(3, 11);
      1: op = $urandom_range(15, 16);
      2: op = $urandom_range(17, 18);
      default: begin
        do op = $urandom_range(0, 31);
        while (op inside {[3:11], [15:18]});
      end
    endcase
    return {5'(op), 27'($urandom)};
  endfunction

  task automatic test_reset();
    clear = 1'b0;
    run = 1'b1;
    ir = 32'h2891_8000;
    mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clock);
      #1 cmp_zero("reset_hold");
    end
    @(negedge clock);
    clear = 1'b1;
    exec("and_0ws", 32'h2891_8000, 0, 1'b0, -1, -1, 1'b1);
    check_idle("and_idle", 2);
  endtask

  task automatic test_wait_states();
    go();
    exec("and_3ws", 32'h2891_8000, 3, 1'b0, -1, -1, 1'b1);
    check_idle("ws_idle", 1);
  endtask

  task automatic test_muldiv();
    go();
    exec("mul", 32'h7891_8000, 0, 1'b0, -1, -1, 1'b0);
    go();
    exec("div", rand_ir(1), 2, 1'b0, -1, -1, 1'b0);
    check_idle("md_idle", 1);
  endtask

  task automatic test_illegal();
    go();
    exec("ill", 32'hF891_8000, 0, 1'b1, -1, -1, 1'b0);
    exec("after_ill", 32'h1891_8000, 1, 1'b0, -1, -1, 1'b0);
    check_idle("ill_idle", 1);
  endtask

  task automatic test_clear();
    go();
    exec("clr", 32'h2891_8000, 1, 1'b1, -1, 5, 1'b0);
    #1 clear = 1'b0;
    run = 1'b0;
    #1 cmp_zero("clr_async");
    @(negedge clock);
    #1 cmp_zero("clr_held");
    clear = 1'b1;
    check_idle("clr_idle", 3);
  endtask

  task automatic test_run_drop();
    go();
    exec("drop", 32'h7891_8000, 1, 1'b0, 2, -1, 1'b0);
    check_idle("drop_idle", 2);
  endtask

  task automatic test_regs32();
    go();
    exec("r31", {5'd3, 5'd31, 5'd1, 5'd2, 12'd0},
         0, 1'b0, -1, -1, 1'b0);
    check_idle("r31_idle", 1);
  endtask

  task automatic test_back_to_back();
    go();
    for (int t = 0; t < 40; t++) begin
      exec("b2b", rand_ir($urandom_range(0, 3)),
           $urandom_range(0, 3), t < 39, -1, -1, 1'b0);
    end
    check_idle("b2b_idle", 2);
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_muldiv();
    test_illegal();
    test_clear();
    test_run_drop();
    test_regs32();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
